multi_cycle_controller: RTL and testbench

- Sequencing control FSM for the multi-cycle RV32I core.
- Produces per-state strobes and mux selects that the single-cycle control path produces combinationally; consumes the same instruction fields and ALU flags from the datapath.
- Adds a memory ready handshake on the shared instruction/data memory.
- Sits between the instruction register, ALU flags, the shared memory port and the multi-cycle datapath.

---
 rtl/rv_ctrl_pkg.sv | 60 ++++++
 rtl/mc_alu_op_decoder.sv | 39 +++
 rtl/multi_cycle_controller.sv | 192 +++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  // Which flavour of ALU operation the current state needs.
  typedef enum logic [1:0] {
    CLS_ADD, CLS_R, CLS_I, CLS_BR
  } alu_class_t;

endpackage

// File: rtl/mc_alu_op_decoder.sv
// Maps funct3/funct7[5] and the state class onto the ALU operation.
module mc_alu_op_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  output logic [2:0]  alu_control,
  output logic        unsigned_sig
);

  // R/I use funct3 directly; branches compare with sub or slt/sltu.
  always_comb begin
    alu_control  = ALU_ADD;
    unsigned_sig = 1'b0;
    case (alu_class)
      CLS_R, CLS_I: begin
        unsigned_sig = (funct3 == 3'b011);
        case (funct3)
          3'b000:  alu_control = (alu_class == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      CLS_BR: begin
        unsigned_sig = funct3[1];
        if (funct3[2:1] == 2'b00) alu_control = ALU_SUB;
        else if (funct3[1])       alu_control = ALU_SLTU;
        else                      alu_control = ALU_SLT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core with shared-memory handshake.
module multi_cycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       lt,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       unsigned_sig,
  output logic       illegal
);

  state_t     state_q, state_d, dec_state;
  alu_class_t alu_class;
  logic       ready, branch_taken;
  logic       pc_w, ir_w, mem_w, reg_w, ill;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  assign ready         = mem_ready | ~MEM_WAIT_EN;
  // During reset the selects show FETCH regardless of the stale state.
  assign dec_state     = rst ? S_FETCH : state_q;

  // ALU class selected by state so the decoder only sees meaningful fields.
  always_comb begin
    case (dec_state)
      S_EXECR:  alu_class = CLS_R;
      S_EXECI:  alu_class = CLS_I;
      S_BRANCH: alu_class = CLS_BR;
      default:  alu_class = CLS_ADD;
    endcase
  end

  mc_alu_op_decoder u_alu_dec (
    .alu_class    (alu_class),
    .funct3       (funct3),
    .funct7_5     (funct7[5]),
    .alu_control  (alu_control),
    .unsigned_sig (unsigned_sig)
  );

  // Branch condition from funct3 and the ALU flags; 010/011 never branch.
  always_comb begin
    case (funct3)
      3'b000:         branch_taken = zero;
      3'b001:         branch_taken = ~zero;
      3'b100, 3'b110: branch_taken = lt;
      3'b101, 3'b111: branch_taken = ~lt;
      default:        branch_taken = 1'b0;
    endcase
  end

  // Per-state output decode and next-state selection.
  always_comb begin
    state_d    = dec_state;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    ill        = 1'b0;
    case (dec_state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (ready) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default: begin
            state_d = S_FETCH;
            ill     = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        pc_w      = branch_taken;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_w      = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        state_d   = S_JALRPC;
      end
      S_JALRPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_w      = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write strobes are suppressed for the whole reset cycle.
  assign pc_write  = pc_w  & ~rst;
  assign ir_write  = ir_w  & ~rst;
  assign mem_write = mem_w & ~rst;
  assign reg_write = reg_w & ~rst;
  assign illegal   = ill   & ~rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized bench: each instruction is expanded into the list of cycles the
// RV32I multi-cycle flow should take, and every cycle's outputs are compared.
module tb_multi_cycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [2:0] imm;
    logic       reg_write;
    logic       uns;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    outs_t o;
    logic  mem;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, lt, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, unsigned_sig, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  outs_t      obs;

  int n_checks = 0;
  int n_pass   = 0;
  int n_instr  = 0;
  step_t steps[$];

  always #5 clk = ~clk;

  multi_cycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .funct3       (funct3),
    .funct7       (funct7),
    .zero         (zero),
    .lt           (lt),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .adr_src      (adr_src),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .result_src   (result_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_control  (alu_control),
    .imm_src      (imm_src),
    .reg_write    (reg_write),
    .unsigned_sig (unsigned_sig),
    .illegal      (illegal)
  );

  assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_control, imm_src, reg_write, unsigned_sig, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic is_legal(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
  endfunction

  // Arithmetic op named by funct3 (subtract only for register form).
  function automatic logic [2:0] want_alu(input logic [2:0] f3, input logic use_sub);
    case (f3)
      3'b000:  return use_sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b011:  return 3'b110;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic want_taken(input logic [2:0] f3, input logic z, input logic l);
    case (f3)
      3'b000:         return z;
      3'b001:         return !z;
      3'b100, 3'b110: return l;
      3'b101, 3'b111: return !l;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic outs_t fetch_outs();
    outs_t o = '0;
    o.src_b = 2'b10;
    o.result_src = 2'b10;
    o.ir_write = 1'b1;
    o.pc_write = 1'b1;
    return o;
  endfunction

  function automatic void push(input outs_t o, input logic m);
    step_t s;
    s.o = o;
    s.mem = m;
    steps.push_back(s);
  endfunction

  function automatic void push_wb();
    outs_t o = '0;
    o.reg_write = 1'b1;
    push(o, 1'b0);
  endfunction

  // Expand one instruction into its expected cycle sequence.
  function automatic void build(input logic [6:0] op_i, input logic [2:0] f3,
                                input logic [6:0] f7, input logic z, input logic l);
    outs_t o;
    steps.delete();
    push(fetch_outs(), 1'b1);
    o = '0; o.src_a = 2'b01; o.src_b = 2'b01; o.imm = 3'b010; o.illegal = !is_legal(op_i);
    push(o, 1'b0);
    case (op_i)
      7'b0000011: begin
        o = '0; o.src_a = 2'b10; o.src_b = 2'b01; o.imm = 3'b000; push(o, 1'b0);
        o = '0; o.adr_src = 1'b1; push(o, 1'b1);
        o = '0; o.result_src = 2'b01; o.reg_write = 1'b1; push(o, 1'b0);
      end
      7'b0100011: begin
        o = '0; o.src_a = 2'b10; o.src_b = 2'b01; o.imm = 3'b001; push(o, 1'b0);
        o = '0; o.adr_src = 1'b1; o.mem_write = 1'b1; push(o, 1'b1);
      end
      7'b0110011: begin
        o = '0; o.src_a = 2'b10; o.src_b = 2'b00; o.alu = want_alu(f3, f7[5]);
        o.uns = (f3 == 3'b011); push(o, 1'b0);
        push_wb();
      end
      7'b0010011: begin
        o = '0; o.src_a = 2'b10; o.src_b = 2'b01; o.imm = 3'b000; o.alu = want_alu(f3, 1'b0);
        o.uns = (f3 == 3'b011); push(o, 1'b0);
        push_wb();
      end
      7'b0110111: begin
        o = '0; o.src_a = 2'b11; o.src_b = 2'b01; o.imm = 3'b100; push(o, 1'b0);
        push_wb();
      end
      7'b1100011: begin
        o = '0; o.src_a = 2'b10; o.src_b = 2'b00;
        o.alu = (f3[2:1] == 2'b00) ? 3'b001 : (f3[1] ? 3'b110 : 3'b101);
        o.uns = f3[1]; o.pc_write = want_taken(f3, z, l); push(o, 1'b0);
      end
      7'b1101111: begin
        o = '0; o.src_a = 2'b01; o.src_b = 2'b10; o.pc_write = 1'b1; push(o, 1'b0);
        push_wb();
      end
      7'b1100111: begin
        o = '0; o.src_a = 2'b10; o.src_b = 2'b01; o.imm = 3'b000; push(o, 1'b0);
        o = '0; o.src_a = 2'b01; o.src_b = 2'b10; o.pc_write = 1'b1; push(o, 1'b0);
        push_wb();
      end
      default: ;
    endcase
  endfunction

  // Run one instruction from FETCH. nwait>=0: memory step wstep stalls nwait
  // cycles and every other step is ready; nwait<0: random readiness.
  task automatic run_instr(input logic [6:0] op_i, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input logic l, input int wstep, input int nwait);
    int    cycles;
    int    w;
    bit    done;
    bit    rdy;
    outs_t want;
    cycles = 0;
    build(op_i, f3, f7, z, l);
    op = op_i; funct3 = f3; funct7 = f7; zero = z; lt = l;
    for (int i = 0; i < steps.size(); i++) begin
      w = 0;
      done = 1'b0;
      while (!done) begin
        if (nwait >= 0)    rdy = !(steps[i].mem && i == wstep && w < nwait);
        else if (steps[i].mem) rdy = (w >= 3) || ($urandom_range(0, 2) != 0);
        else               rdy = 1'($urandom_range(0, 1));
        mem_ready = rdy;
        want = steps[i].o;
        if (steps[i].mem && !rdy) begin
          want.ir_write = 1'b0;
          want.pc_write = 1'b0;
        end
        @(negedge clk);
        check($sformatf("instr%0d op=%b step%0d wait%0d", n_instr, op_i, i, w), 32'(obs), 32'(want));
        @(posedge clk); #1;
        cycles++;
        if (steps[i].mem && !rdy) w++;
        else done = 1'b1;
      end
    end
    $display("instr %0d op=%b f3=%b f7=%b z=%b lt=%b cycles=%0d", n_instr, op_i, f3, f7, z, l, cycles);
    n_instr++;
  endtask

  initial begin
    outs_t rst_want;
    logic [6:0] ops[10];
    logic [2:0] f3;
    rst_want = fetch_outs();
    rst_want.ir_write = 1'b0;
    rst_want.pc_write = 1'b0;
    rst = 1'b1; mem_ready = 1'b1; op = '0; funct3 = '0; funct7 = '0; zero = 1'b0; lt = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset outputs", 32'(obs), 32'(rst_want));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, 0);  // add
    run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, 0);  // sub
    run_instr(7'b0000011, 3'b010, 7'b0000000, 0, 0, 3, 2);  // lw, 2 waits
    run_instr(7'b0100011, 3'b010, 7'b0000000, 0, 0, 3, 1);  // sw, 1 wait
    run_instr(7'b1100011, 3'b000, 7'b0000000, 1, 0, 0, 0);  // beq taken
    run_instr(7'b1100011, 3'b001, 7'b0000000, 1, 0, 0, 0);  // bne not taken
    run_instr(7'b1100011, 3'b110, 7'b0000000, 0, 1, 0, 0);  // bltu taken
    run_instr(7'b1100011, 3'b011, 7'b0000000, 1, 1, 0, 0);  // funct3 011 never taken
    run_instr(7'b1111111, 3'b000, 7'b0000000, 0, 0, 0, 0);  // illegal
    run_instr(7'b1100111, 3'b000, 7'b0000000, 0, 0, 0, 0);  // jalr
    run_instr(7'b1101111, 3'b000, 7'b0000000, 0, 0, 0, 0);  // jal
    run_instr(7'b0110111, 3'b000, 7'b0000000, 0, 0, 0, 0);  // lui
    run_instr(7'b0010011, 3'b000, 7'b0100000, 0, 0, 0, 0);  // addi, no subi
    run_instr(7'b0010011, 3'b011, 7'b0000000, 0, 0, 0, 0);  // sltiu
    run_instr(7'b0110011, 3'b111, 7'b0000000, 0, 0, 0, 2);  // and, fetch waits

    // Reset in the middle of a load: strobes stay low, then a clean FETCH.
    op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid-instruction reset", 32'(obs), 32'(rst_want));
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(7'b0110011, 3'b100, 7'b0000000, 0, 0, 0, 0);  // xor after reset

    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0000000, 7'b1110011};
    for (int k = 0; k < 200; k++) begin
      logic [6:0] o_r;
      o_r = ops[$urandom_range(0, 9)];
      f3 = 3'($urandom);
      if ((o_r == 7'b0110011 || o_r == 7'b0010011) && (f3 == 3'b001 || f3 == 3'b101))
        f3 = 3'b110;
      run_instr(o_r, f3, 7'($urandom), 1'($urandom), 1'($urandom), 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
